// File: rtl/mem_stage_ctl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_ctl_if : execute-side, memory-side and write-back signals of the
//                    memory pipeline stage. slave = stage, master = its driver.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface mem_stage_ctl_if;
   logic        InValid;
   logic [15:0] Addr;
   logic [15:0] WriteData;
   logic        MemRead;
   logic        MemWrite;
   logic [15:0] PCplus2In;
   logic        MemtoRegIn;
   logic        AdrLinkIn;
   logic        RegWriteIn;
   logic [2:0]  WriteRegIn;
   logic        Stall;
   logic        MemReq;
   logic        MemWr;
   logic [15:0] MemAddr;
   logic [15:0] MemWData;
   logic [15:0] MemRData;
   logic        MemAck;
   logic        OutValid;
   logic [15:0] DataOut;
   logic [15:0] MemOut;
   logic [15:0] PCplus2;
   logic        MemtoReg;
   logic        AdrLink;
   logic        RegWrite;
   logic [2:0]  WriteReg;
   logic        MemErr;

   modport slave (
      input  InValid, Addr, WriteData, MemRead, MemWrite, PCplus2In,
             MemtoRegIn, AdrLinkIn, RegWriteIn, WriteRegIn, MemRData, MemAck,
      output Stall, MemReq, MemWr, MemAddr, MemWData, OutValid, DataOut,
             MemOut, PCplus2, MemtoReg, AdrLink, RegWrite, WriteReg, MemErr
   );

   modport master (
      output InValid, Addr, WriteData, MemRead, MemWrite, PCplus2In,
             MemtoRegIn, AdrLinkIn, RegWriteIn, WriteRegIn, MemRData, MemAck,
      input  Stall, MemReq, MemWr, MemAddr, MemWData, OutValid, DataOut,
             MemOut, PCplus2, MemtoReg, AdrLink, RegWrite, WriteReg, MemErr
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_stage_ctl : memory stage with MEM/WB register and req/ack data-memory
//                 handshake. Optional ack timeout abort via MEM_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module mem_stage_ctl #(
   parameter int ACK_TIMEOUT = 15
) (
   input logic           clk,
   input logic           rst,
   mem_stage_ctl_if.slave bus
);
   if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
      $error("ACK_TIMEOUT out of range 1..255");
   end

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        w_op;
   logic        w_pass;
   logic        w_bad;
   logic        w_issue;
   logic        w_done;
   logic        w_abort;
   logic        w_timeout;

   logic [15:0] r_lat_pc;
   logic        r_lat_m2r;
   logic        r_lat_al;
   logic        r_lat_rw;
   logic [2:0]  r_lat_wreg;

   assign w_op   = bus.InValid & (bus.MemRead ^ bus.MemWrite);
   assign w_pass = (r_state == S_IDLE) & bus.InValid & ~(bus.MemRead ^ bus.MemWrite);
   assign w_bad  = w_pass & bus.MemRead & bus.MemWrite;

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] c_LAST_WAIT = 8'(ACK_TIMEOUT - 1);
   logic [7:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || r_state != S_WAIT) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign w_timeout = (r_state == S_WAIT) && (r_cnt == c_LAST_WAIT);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An ack arriving on the timeout cycle still completes normally.
   always_comb begin
      w_state_nxt = r_state;
      bus.Stall   = 1'b0;
      w_issue     = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_op) begin
               bus.Stall   = 1'b1;
               w_issue     = 1'b1;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            bus.Stall = ~bus.MemAck;
            if (bus.MemAck) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (w_timeout) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.MemReq   <= 1'b0;
         bus.MemWr    <= 1'b0;
         bus.MemAddr  <= 16'h0000;
         bus.MemWData <= 16'h0000;
         bus.OutValid <= 1'b0;
         bus.DataOut  <= 16'h0000;
         bus.MemOut   <= 16'h0000;
         bus.PCplus2  <= 16'h0000;
         bus.MemtoReg <= 1'b0;
         bus.AdrLink  <= 1'b0;
         bus.RegWrite <= 1'b0;
         bus.WriteReg <= 3'b000;
         bus.MemErr   <= 1'b0;
         r_lat_pc     <= 16'h0000;
         r_lat_m2r    <= 1'b0;
         r_lat_al     <= 1'b0;
         r_lat_rw     <= 1'b0;
         r_lat_wreg   <= 3'b000;
      end else begin
         bus.OutValid <= 1'b0;
         bus.MemErr   <= 1'b0;
         bus.RegWrite <= 1'b0;

         if (w_issue) begin
            bus.MemReq   <= 1'b1;
            bus.MemWr    <= bus.MemWrite;
            bus.MemAddr  <= bus.Addr;
            bus.MemWData <= bus.WriteData;
            r_lat_pc     <= bus.PCplus2In;
            r_lat_m2r    <= bus.MemtoRegIn;
            r_lat_al     <= bus.AdrLinkIn;
            r_lat_rw     <= bus.RegWriteIn;
            r_lat_wreg   <= bus.WriteRegIn;
         end

         if (w_pass) begin
            bus.OutValid <= 1'b1;
            bus.DataOut  <= bus.Addr;
            bus.MemOut   <= 16'h0000;
            bus.PCplus2  <= bus.PCplus2In;
            bus.MemtoReg <= bus.MemtoRegIn;
            bus.AdrLink  <= bus.AdrLinkIn;
            bus.RegWrite <= bus.RegWriteIn & ~w_bad;
            bus.WriteReg <= bus.WriteRegIn;
            bus.MemErr   <= w_bad;
         end

         // MemAddr and MemWr still hold the issued access, so they double as
         // the latched Addr and store flag.
         if (w_done || w_abort) begin
            bus.MemReq   <= 1'b0;
            bus.OutValid <= 1'b1;
            bus.DataOut  <= bus.MemAddr;
            bus.PCplus2  <= r_lat_pc;
            bus.MemtoReg <= r_lat_m2r;
            bus.AdrLink  <= r_lat_al;
            bus.WriteReg <= r_lat_wreg;
            if (w_done) begin
               bus.MemOut   <= bus.MemWr ? 16'h0000 : bus.MemRData;
               bus.RegWrite <= r_lat_rw;
            end else begin
               bus.MemOut   <= 16'hFFFF;
               bus.MemErr   <= 1'b1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_stage_ctl : directed plus randomized transactions against a
//                    transaction-level write-back model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mem_stage_ctl;
   localparam int TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst;
   mem_stage_ctl_if bus ();

   mem_stage_ctl #(.ACK_TIMEOUT(TB_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        rd, wr;
      logic [15:0] addr, wdata, rdata, pc;
      logic        m2r, al, rw;
      logic [2:0]  wreg;
      int          delay;
   } txn_t;

   typedef struct {
      logic [15:0] data, mem, pc;
      logic        m2r, al, rw, err, chk_mem;
      logic [2:0]  wreg;
   } wb_t;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Write-back result a transaction must produce.
   function automatic wb_t model(input txn_t t);
      wb_t e;
      e.data    = t.addr;
      e.pc      = t.pc;
      e.m2r     = t.m2r;
      e.al      = t.al;
      e.wreg    = t.wreg;
      e.err     = t.rd & t.wr;
      e.rw      = e.err ? 1'b0 : t.rw;
      e.mem     = (t.rd && !t.wr) ? t.rdata : 16'h0000;
      e.chk_mem = !e.err;
      return e;
   endfunction

   task automatic drive_idle();
      bus.InValid  = 1'b0;
      bus.MemRead  = 1'($urandom);
      bus.MemWrite = 1'($urandom);
      bus.Addr     = 16'($urandom);
      bus.MemAck   = 1'b0;
   endtask

   task automatic run_txn(input txn_t t, input bit idle_after);
      wb_t e = model(t);
      bit  is_op = t.rd ^ t.wr;
      bus.InValid    = 1'b1;
      bus.MemRead    = t.rd;
      bus.MemWrite   = t.wr;
      bus.Addr       = t.addr;
      bus.WriteData  = t.wdata;
      bus.PCplus2In  = t.pc;
      bus.MemtoRegIn = t.m2r;
      bus.AdrLinkIn  = t.al;
      bus.RegWriteIn = t.rw;
      bus.WriteRegIn = t.wreg;
      bus.MemAck     = 1'b0;
      #1;
      check("stall_accept", 16'(bus.Stall), 16'(is_op));
      step();
      if (is_op) begin
         for (int k = 0; k <= t.delay; k++) begin
            check("req_held", 16'(bus.MemReq), 16'h1);
            check("mem_addr", bus.MemAddr, t.addr);
            check("mem_wr", 16'(bus.MemWr), 16'(t.wr));
            if (t.wr) check("mem_wdata", bus.MemWData, t.wdata);
            check("wait_ov", 16'(bus.OutValid), 16'h0);
            check("wait_rw", 16'(bus.RegWrite), 16'h0);
            if (k == t.delay) begin
               bus.MemAck   = 1'b1;
               bus.MemRData = t.rdata;
            end
            #1;
            check("wait_stall", 16'(bus.Stall), (k == t.delay) ? 16'h0 : 16'h1);
            step();
         end
         bus.MemAck   = 1'b0;
         bus.MemRData = 16'($urandom);
      end
      check("wb_valid", 16'(bus.OutValid), 16'h1);
      check("wb_data", bus.DataOut, e.data);
      if (e.chk_mem) check("wb_mem", bus.MemOut, e.mem);
      check("wb_pc", bus.PCplus2, e.pc);
      check("wb_m2r", 16'(bus.MemtoReg), 16'(e.m2r));
      check("wb_al", 16'(bus.AdrLink), 16'(e.al));
      check("wb_rw", 16'(bus.RegWrite), 16'(e.rw));
      check("wb_wreg", 16'(bus.WriteReg), 16'(e.wreg));
      check("wb_err", 16'(bus.MemErr), 16'(e.err));
      check("wb_req", 16'(bus.MemReq), 16'h0);
      if (idle_after) begin
         drive_idle();
         #1;
         check("idle_stall", 16'(bus.Stall), 16'h0);
         step();
         check("idle_ov", 16'(bus.OutValid), 16'h0);
         check("idle_rw", 16'(bus.RegWrite), 16'h0);
         check("idle_err", 16'(bus.MemErr), 16'h0);
      end
   endtask

   function automatic txn_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] rdata, input int delay);
      txn_t t;
      t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
      t.pc = 16'($urandom); t.m2r = 1'($urandom); t.al = 1'($urandom);
      t.rw = 1'b1; t.wreg = 3'($urandom); t.delay = delay;
      return t;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      txn_t t;
      int   kind;
      bus.InValid = 0; bus.Addr = 0; bus.WriteData = 0; bus.MemRead = 0; bus.MemWrite = 0;
      bus.PCplus2In = 0; bus.MemtoRegIn = 0; bus.AdrLinkIn = 0; bus.RegWriteIn = 0;
      bus.WriteRegIn = 0; bus.MemRData = 0; bus.MemAck = 0;

      rst = 1'b1;
      step();
      step();
      check("rst_stall", 16'(bus.Stall), 16'h0);
      check("rst_req", 16'(bus.MemReq), 16'h0);
      check("rst_wr", 16'(bus.MemWr), 16'h0);
      check("rst_addr", bus.MemAddr, 16'h0);
      check("rst_wdata", bus.MemWData, 16'h0);
      check("rst_ov", 16'(bus.OutValid), 16'h0);
      check("rst_data", bus.DataOut, 16'h0);
      check("rst_mem", bus.MemOut, 16'h0);
      check("rst_pc", bus.PCplus2, 16'h0);
      check("rst_ctl", {13'h0, bus.MemtoReg, bus.AdrLink, bus.RegWrite}, 16'h0);
      check("rst_wreg", 16'(bus.WriteReg), 16'h0);
      check("rst_err", 16'(bus.MemErr), 16'h0);
      rst = 1'b0;

      t = mk(1'b0, 1'b0, 16'h1234, 16'h0, 16'h0, 0);
      t.wreg = 3'd3;
      run_txn(t, 1'b1);
      run_txn(mk(1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF, 3), 1'b1);
      run_txn(mk(1'b0, 1'b1, 16'h0008, 16'h00AA, 16'h5555, 1), 1'b1);
      run_txn(mk(1'b1, 1'b1, 16'h0077, 16'h0011, 16'h0, 0), 1'b1);

      // Stray ack in IDLE.
      bus.MemAck = 1'b1;
      step();
      bus.MemAck = 1'b0;
      check("stray_ack_ov", 16'(bus.OutValid), 16'h0);
      check("stray_ack_req", 16'(bus.MemReq), 16'h0);

      // Reset while waiting, then a late ack.
      bus.InValid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Addr = 16'h0100;
      step();
      step();
      check("midwait_req", 16'(bus.MemReq), 16'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.InValid = 1'b0;
      check("rst_wait_req", 16'(bus.MemReq), 16'h0);
      check("rst_wait_ov", 16'(bus.OutValid), 16'h0);
      bus.MemAck = 1'b1;
      #1;
      check("rst_wait_stall", 16'(bus.Stall), 16'h0);
      step();
      bus.MemAck = 1'b0;
      check("late_ack_ov", 16'(bus.OutValid), 16'h0);
      check("late_ack_req", 16'(bus.MemReq), 16'h0);

`ifdef MEM_TIMEOUT_EN
      bus.InValid = 1'b1; bus.MemRead = 1'b1; bus.MemWrite = 1'b0; bus.Addr = 16'h0200;
      bus.RegWriteIn = 1'b1;
      step();
      bus.InValid = 1'b0;
      for (int k = 0; k < TB_TIMEOUT; k++) begin
         check("to_req", 16'(bus.MemReq), 16'h1);
         step();
      end
      check("to_err", 16'(bus.MemErr), 16'h1);
      check("to_ov", 16'(bus.OutValid), 16'h1);
      check("to_mem", bus.MemOut, 16'hFFFF);
      check("to_rw", 16'(bus.RegWrite), 16'h0);
      check("to_req_off", 16'(bus.MemReq), 16'h0);
      check("to_stall", 16'(bus.Stall), 16'h0);
      step();
`endif

      for (int n = 0; n < 40; n++) begin
         kind = int'($urandom_range(0, 9));
         t = mk(1'b0, 1'b0, 16'($urandom), 16'($urandom), 16'($urandom),
                int'($urandom_range(0, TB_TIMEOUT - 1)));
         t.rw = 1'($urandom);
         if (kind >= 3 && kind <= 5) t.rd = 1'b1;
         else if (kind >= 6 && kind <= 8) t.wr = 1'b1;
         else if (kind == 9) begin t.rd = 1'b1; t.wr = 1'b1; end
         run_txn(t, 1'($urandom));
      end
      drive_idle();
      step();
      check("final_ov", 16'(bus.OutValid), 16'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
`default_nettype wire
